// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types: instruction/register words, fetch FSM states and fault codes.
package instr_fetch_unit_pkg;

  typedef logic [31:0] instruction_t;
  typedef logic [31:0] register_t;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT,
    FS_HOLD,
    FS_FAULT
  } fetch_state_t;

  typedef logic [1:0] fetch_fault_t;

  localparam fetch_fault_t FF_NONE     = 2'b00;
  localparam fetch_fault_t FF_MISALIGN = 2'b01;
  localparam fetch_fault_t FF_TIMEOUT  = 2'b10;

endpackage

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch: PC in, req/gnt/rvalid imem read, valid/ready instr out.
// Handshakes: imem request accepted when mem_req && mem_gnt; instruction consumed when instr_valid && instr_ready.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_load,
  input  logic [XLEN-1:0] pc_in,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output instruction_t    instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fault,
  output fetch_fault_t    fault_code
);

  localparam int TW = $clog2(TIMEOUT + 1);

  fetch_state_t   state;
  logic [TW-1:0]  timer;
  logic           kill;
  logic           misaligned;
  logic           timer_expired;

  assign misaligned    = (pc_in[1:0] != 2'b00);
  assign timer_expired = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FS_IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fault       <= 1'b0;
      fault_code  <= FF_NONE;
      timer       <= '0;
      kill        <= 1'b0;
    end else begin
      if (timer != TW'(TIMEOUT)) timer <= timer + 1'b1;

      case (state)
        // A new PC from IDLE, FAULT or HOLD always starts a fresh fetch and drops any held word.
        FS_IDLE, FS_FAULT, FS_HOLD: begin
          if (pc_load) begin
            instr_valid <= 1'b0;
            timer       <= '0;
            kill        <= 1'b0;
            if (misaligned) begin
              state      <= FS_FAULT;
              mem_req    <= 1'b0;
              fault      <= 1'b1;
              fault_code <= FF_MISALIGN;
            end else begin
              state      <= FS_REQ;
              mem_req    <= 1'b1;
              mem_addr   <= pc_in;
              fault      <= 1'b0;
              fault_code <= FF_NONE;
            end
          end else if (state == FS_HOLD && instr_ready) begin
            state       <= FS_IDLE;
            instr_valid <= 1'b0;
            timer       <= '0;
          end
        end

        FS_REQ: begin
          if (mem_gnt) begin
            state   <= FS_WAIT;
            mem_req <= 1'b0;
            timer   <= '0;
            // Granted in the same cycle as a redirect: the old response is still owed, so kill it.
            if (pc_load) begin
              if (misaligned) begin
                state      <= FS_FAULT;
                fault      <= 1'b1;
                fault_code <= FF_MISALIGN;
              end else begin
                kill     <= 1'b1;
                mem_addr <= pc_in;
              end
            end
          end else if (pc_load) begin
            timer <= '0;
            if (misaligned) begin
              state      <= FS_FAULT;
              mem_req    <= 1'b0;
              fault      <= 1'b1;
              fault_code <= FF_MISALIGN;
            end else begin
              mem_addr <= pc_in;
            end
          end else if (timer_expired) begin
            state      <= FS_FAULT;
            mem_req    <= 1'b0;
            fault      <= 1'b1;
            fault_code <= FF_TIMEOUT;
            timer      <= '0;
          end
        end

        FS_WAIT: begin
          if (pc_load) begin
            if (misaligned) begin
              state      <= FS_FAULT;
              kill       <= 1'b0;
              fault      <= 1'b1;
              fault_code <= FF_MISALIGN;
              timer      <= '0;
            end else if (mem_rvalid) begin
              state    <= FS_REQ;
              mem_req  <= 1'b1;
              mem_addr <= pc_in;
              kill     <= 1'b0;
              timer    <= '0;
            end else begin
              kill     <= 1'b1;
              mem_addr <= pc_in;
            end
          end else if (mem_rvalid) begin
            timer <= '0;
            if (kill) begin
              state   <= FS_REQ;
              mem_req <= 1'b1;
              kill    <= 1'b0;
            end else begin
              state       <= FS_HOLD;
              instr       <= mem_rdata;
              instr_pc    <= mem_addr;
              instr_valid <= 1'b1;
            end
          end else if (timer_expired) begin
            state      <= FS_FAULT;
            kill       <= 1'b0;
            fault      <= 1'b1;
            fault_code <= FF_TIMEOUT;
            timer      <= '0;
          end
        end

        default: begin
          state   <= FS_IDLE;
          mem_req <= 1'b0;
          timer   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch latency, back-pressure, faults, redirects, reset.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic            clk;
  logic            rst;
  logic            pc_load;
  logic [XLEN-1:0] pc_in;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  instruction_t    instr;
  logic [XLEN-1:0] instr_pc;
  logic            fault;
  fetch_fault_t    fault_code;

  int n_cmp;
  int n_err;

  instr_fetch_unit #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_load     (pc_load),
    .pc_in       (pc_in),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; inputs set before the call are sampled at this edge, outputs settle 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [XLEN-1:0] pc);
    pc_load = 1'b1;
    pc_in   = pc;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic grant();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".mem_req"},     64'(mem_req),     64'd0);
    check({tag, ".mem_addr"},    64'(mem_addr),    64'd0);
    check({tag, ".instr_valid"}, 64'(instr_valid), 64'd0);
    check({tag, ".instr"},       64'(instr),       64'd0);
    check({tag, ".instr_pc"},    64'(instr_pc),    64'd0);
    check({tag, ".fault"},       64'(fault),       64'd0);
    check({tag, ".fault_code"},  64'(fault_code),  64'd0);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b0;
    pc_load     = 1'b0;
    pc_in       = '0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    instr_ready = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b1;

    // 1: basic fetch, valid on third cycle after pc_load
    load_pc(32'h100);
    check("t1.req",      64'(mem_req),     64'd1);
    check("t1.addr",     64'(mem_addr),    64'h100);
    check("t1.valid_c1", 64'(instr_valid), 64'd0);
    grant();
    check("t1.req_drop", 64'(mem_req),     64'd0);
    check("t1.valid_c2", 64'(instr_valid), 64'd0);
    respond(32'h00A00093);
    check("t1.valid",    64'(instr_valid), 64'd1);
    check("t1.instr",    64'(instr),       64'h00A00093);
    check("t1.pc",       64'(instr_pc),    64'h100);
    accept();
    check("t1.valid_off", 64'(instr_valid), 64'd0);

    // 2: back-pressure keeps word stable
    load_pc(32'h104);
    grant();
    respond(32'h00108113);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2.valid", 64'(instr_valid), 64'd1);
      check("t2.instr", 64'(instr),       64'h00108113);
      check("t2.pc",    64'(instr_pc),    64'h104);
    end
    accept();
    check("t2.valid_off", 64'(instr_valid), 64'd0);

    // 3: misaligned PC faults without a bus request
    load_pc(32'h102);
    check("t3.fault", 64'(fault),      64'd1);
    check("t3.code",  64'(fault_code), 64'h1);
    for (int i = 0; i < 3; i++) begin
      check("t3.no_req", 64'(mem_req), 64'd0);
      tick();
    end
    load_pc(32'h104);
    check("t3.fault_clr", 64'(fault),      64'd0);
    check("t3.code_clr",  64'(fault_code), 64'h0);
    check("t3.req",       64'(mem_req),    64'd1);
    check("t3.addr",      64'(mem_addr),   64'h104);
    grant();
    respond(32'h11111111);
    accept();

    // 4: redirect in WAIT drops the in-flight word
    load_pc(32'h200);
    grant();
    load_pc(32'h300);
    check("t4.req_low", 64'(mem_req), 64'd0);
    respond(32'hDEADBEEF);
    check("t4.dropped", 64'(instr_valid), 64'd0);
    check("t4.rereq",   64'(mem_req),     64'd1);
    check("t4.addr",    64'(mem_addr),    64'h300);
    grant();
    respond(32'h22222222);
    check("t4.valid", 64'(instr_valid), 64'd1);
    check("t4.pc",    64'(instr_pc),    64'h300);
    check("t4.instr", 64'(instr),       64'h22222222);
    accept();

    // 4b: pc_load together with rvalid in WAIT
    load_pc(32'h400);
    grant();
    pc_load    = 1'b1;
    pc_in      = 32'h500;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h33333333;
    tick();
    pc_load    = 1'b0;
    mem_rvalid = 1'b0;
    check("t4b.dropped", 64'(instr_valid), 64'd0);
    check("t4b.req",     64'(mem_req),     64'd1);
    check("t4b.addr",    64'(mem_addr),    64'h500);
    grant();
    respond(32'h44444444);
    check("t4b.pc", 64'(instr_pc), 64'h500);
    accept();

    // 4c: redirect in REQ before gnt, then from HOLD without a handshake
    load_pc(32'h600);
    load_pc(32'h640);
    check("t4c.req",  64'(mem_req),  64'd1);
    check("t4c.addr", 64'(mem_addr), 64'h640);
    grant();
    respond(32'h55555555);
    check("t4c.pc", 64'(instr_pc), 64'h640);
    load_pc(32'h680);
    check("t4c.hold_drop", 64'(instr_valid), 64'd0);
    check("t4c.hold_req",  64'(mem_req),     64'd1);
    check("t4c.hold_addr", 64'(mem_addr),    64'h680);
    grant();
    respond(32'h66666666);
    accept();

    // 5: grant timeout after TIMEOUT cycles of request
    load_pc(32'h700);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("t5.req_last", 64'(mem_req), 64'd1);
    check("t5.no_fault", 64'(fault),   64'd0);
    tick();
    check("t5.fault",   64'(fault),      64'd1);
    check("t5.code",    64'(fault_code), 64'h2);
    check("t5.req_off", 64'(mem_req),    64'd0);

    // 5b: rvalid timeout
    load_pc(32'h800);
    check("t5b.fault_clr", 64'(fault), 64'd0);
    grant();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("t5b.no_fault", 64'(fault), 64'd0);
    tick();
    check("t5b.fault", 64'(fault),       64'd1);
    check("t5b.code",  64'(fault_code),  64'h2);
    check("t5b.valid", 64'(instr_valid), 64'd0);

    // 6: reset mid-WAIT, late rvalid ignored
    load_pc(32'h900);
    grant();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    respond(32'h77777777);
    check_reset_values("t6");
    tick();
    check("t6.still_idle", 64'(instr_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
